// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC request scheduler: Q4.20 angle
// constants, the scheduler state encoding and the signed angle word type.
package cordic_pkg;

  localparam int ARG_W = 24;

  typedef logic signed [ARG_W-1:0] arg_t;

  // pi and pi/2 in signed Q4.20
  localparam arg_t PI      = 24'sh3243F7;
  localparam arg_t HALF_PI = 24'sh1921FB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// above the pointer, wrapping around, and reports it one-hot and as an index.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_any
);

  // Walk the requesters starting at ptr; the first hit wins and masks the rest.
  always_comb begin
    int         idx_i;
    logic [ID_W-1:0] idx_s;
    logic       hit_s;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx_i     = 0;
    idx_s     = '0;
    hit_s     = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      idx_i            = (int'(ptr) + off) % N_REQ;
      idx_s            = ID_W'(idx_i);
      hit_s            = ~grant_any & req[idx_s];
      grant[idx_s]     = hit_s;
      grant_idx        = hit_s ? idx_s : grant_idx;
      grant_any        = grant_any | hit_s;
    end
  end

endmodule

// File: rtl/cordic_sched.sv
// Round-robin front end for one shared iterative CORDIC rotator. Accepts
// tagged angle requests, folds them into the core's convergence range,
// drives the core's level-sensitive load, supervises the job with a
// watchdog and returns sign-corrected cos/sin on one response channel.
module cordic_sched
  import cordic_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int ARG_WIDTH = 24,
  parameter int TIMEOUT   = 63
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*ARG_WIDTH-1:0] req_angle,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [ARG_WIDTH-1:0]       rsp_cos,
  output logic [ARG_WIDTH-1:0]       rsp_sin,
  output logic                       core_data_loaded,
  output logic [ARG_WIDTH-1:0]       core_angle,
  input  logic [ARG_WIDTH-1:0]       core_x,
  input  logic [ARG_WIDTH-1:0]       core_y,
  input  logic                       core_data_computed,
  output logic                       err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic signed [ARG_WIDTH-1:0] PI_C   = ARG_WIDTH'(PI);
  localparam logic signed [ARG_WIDTH-1:0] HALF_C = ARG_WIDTH'(HALF_PI);

  state_t                        state_r;
  state_t                        state_next_s;
  logic [ID_W-1:0]               ptr_r;
  logic [N_REQ-1:0]              grant_s;
  logic [ID_W-1:0]               grant_idx_s;
  logic                          grant_any_s;
  logic [ARG_WIDTH-1:0]          ang_arr_s [N_REQ];
  logic signed [ARG_WIDTH-1:0]   sel_angle_s;
  logic signed [ARG_WIDTH-1:0]   fold_angle_s;
  logic                          fold_flip_s;
  logic                          accept_s;
  logic                          timeout_s;
  logic [ID_W-1:0]               id_r;
  logic [ARG_WIDTH-1:0]          angle_r;
  logic                          flip_r;
  logic [CNT_W-1:0]              cnt_r;
  logic                          loaded_r;
  logic                          rsp_valid_r;
  logic [ID_W-1:0]               rsp_id_r;
  logic [ARG_WIDTH-1:0]          rsp_cos_r;
  logic [ARG_WIDTH-1:0]          rsp_sin_r;
  logic                          err_r;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_any (grant_any_s)
  );

  // Unpack the flat angle bus so the granted slot can be picked by index.
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign ang_arr_s[g] = req_angle[g*ARG_WIDTH +: ARG_WIDTH];
  end

  assign sel_angle_s = $signed(ang_arr_s[grant_idx_s]);
  assign accept_s    = (state_r == IDLE) && grant_any_s;
  assign timeout_s   = (state_r == WAIT) && !core_data_computed &&
                       (cnt_r == CNT_W'(TIMEOUT - 1));

  // Grants are only offered while idle; the arbiter never picks an invalid requester.
  always_comb begin
    req_ready = '0;
    if (state_r == IDLE) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end
  end

  // Fold |angle| > pi/2 by half a turn; the result sign is restored on completion.
  always_comb begin
    fold_angle_s = sel_angle_s;
    fold_flip_s  = 1'b0;
    if (sel_angle_s > HALF_C) begin
      fold_angle_s = sel_angle_s - PI_C;
      fold_flip_s  = 1'b1;
    end else if (sel_angle_s < -HALF_C) begin
      fold_angle_s = sel_angle_s + PI_C;
      fold_flip_s  = 1'b1;
    end else begin
      fold_angle_s = sel_angle_s;
      fold_flip_s  = 1'b0;
    end
  end

  // Job sequencing: accept -> one load cycle -> wait for core -> hold response.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = LOAD;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD: state_next_s = WAIT;
      WAIT: begin
        if (core_data_computed) begin
          state_next_s = RESP;
        end else if (timeout_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Capture the accepted job and advance the round-robin pointer past it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r   <= '0;
      id_r    <= '0;
      angle_r <= '0;
      flip_r  <= 1'b0;
    end else if (accept_s) begin
      ptr_r   <= (grant_idx_s == ID_W'(N_REQ - 1)) ? '0 : grant_idx_s + ID_W'(1);
      id_r    <= grant_idx_s;
      angle_r <= fold_angle_s;
      flip_r  <= fold_flip_s;
    end
  end

  // Load level is high only for the cycle after accept, so every job gives a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loaded_r <= 1'b0;
    end else begin
      loaded_r <= accept_s;
    end
  end

  // Watchdog: counts cycles spent waiting for the core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (state_r == LOAD) begin
      cnt_r <= '0;
    end else if (state_r == WAIT) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Register the sign-corrected result and hold it until the response handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_cos_r   <= '0;
      rsp_sin_r   <= '0;
    end else if ((state_r == WAIT) && core_data_computed) begin
      rsp_valid_r <= 1'b1;
      rsp_id_r    <= id_r;
      rsp_cos_r   <= flip_r ? -core_x : core_x;
      rsp_sin_r   <= flip_r ? -core_y : core_y;
    end else if (rsp_valid_r && rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end
  end

  // Sticky hang flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (timeout_s) begin
      err_r <= 1'b1;
    end
  end

  assign core_data_loaded = loaded_r;
  assign core_angle       = angle_r;
  assign rsp_valid        = rsp_valid_r;
  assign rsp_id           = rsp_id_r;
  assign rsp_cos          = rsp_cos_r;
  assign rsp_sin          = rsp_sin_r;
  assign err_timeout      = err_r;

endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched: behavioural CORDIC core, per-requester command
// queues, a round-robin/trig reference model and a scoreboard monitor.
module tb_cordic_sched;
  import cordic_pkg::*;

  localparam int N_REQ    = 4;
  localparam int ID_W     = 2;
  localparam int AW       = 24;
  localparam int TMO      = 63;
  localparam int CORE_LAT = 18;
  localparam int TOL      = 32;
  localparam int PI_I     = 32'h3243F7;
  localparam int HALF_I   = 32'h1921FB;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [N_REQ*AW-1:0]   req_angle;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [AW-1:0]         rsp_cos;
  logic [AW-1:0]         rsp_sin;
  logic                  core_data_loaded;
  logic [AW-1:0]         core_angle;
  logic [AW-1:0]         core_x;
  logic [AW-1:0]         core_y;
  logic                  core_data_computed;
  logic                  err_timeout;

  typedef struct {
    int id;
    int cosv;
    int sinv;
  } exp_t;

  exp_t exp_q[$];
  int   cmd_q[N_REQ][$];
  int   acc_cyc_q[$];
  int   rsp_cyc_q[$];
  int   grant_log[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   load_pulses = 0;
  int   accepts = 0;
  bit   suppress = 1'b0;
  int   rdy_mode = 0;

  cordic_sched #(
    .N_REQ(N_REQ), .ID_W(ID_W), .ARG_WIDTH(AW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_angle(req_angle),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_cos(rsp_cos), .rsp_sin(rsp_sin),
    .core_data_loaded(core_data_loaded), .core_angle(core_angle),
    .core_x(core_x), .core_y(core_y), .core_data_computed(core_data_computed),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int sx(input logic [AW-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int q_cos(input int a);
    return int'($cos(real'(a) / 1048576.0) * 1048576.0);
  endfunction

  function automatic int q_sin(input int a);
    return int'($sin(real'(a) / 1048576.0) * 1048576.0);
  endfunction

  function automatic int rand_angle();
    return int'($urandom_range(0, 2 * PI_I)) - PI_I;
  endfunction

  // Requester driver plus round-robin reference and scoreboard push on accept.
  logic [N_REQ-1:0] hs;
  initial begin
    int model_ptr;
    int id;
    int exp_id;
    int a;
    int c;
    bit load_chk;
    int load_a;
    req_valid = '0;
    req_angle = '0;
    model_ptr = 0;
    load_chk  = 1'b0;
    load_a    = 0;
    forever begin
      @(negedge clk);
      hs = '0;
      if (rst) begin
        model_ptr = 0;
        load_chk  = 1'b0;
      end else begin
        if (load_chk) begin
          c = sx(core_angle);
          chk(core_data_loaded == 1'b1, "load_latency", core_data_loaded, 1);
          chk(c <= HALF_I && c >= -HALF_I &&
              (load_a - c == 0 || load_a - c == PI_I || load_a - c == -PI_I),
              "core_angle_fold", c, load_a);
          load_chk = 1'b0;
        end
        if (req_ready != '0)
          chk((req_ready & ~req_valid) == '0, "ready_to_invalid", req_ready, req_valid);
        hs = req_valid & req_ready;
        if (hs != '0) begin
          chk($countones(hs) == 1, "ready_onehot", hs, 1);
          id = 0;
          for (int i = N_REQ - 1; i >= 0; i--) if (hs[i]) id = i;
          exp_id = -1;
          for (int k = 0; k < N_REQ; k++)
            if (exp_id < 0 && req_valid[(model_ptr + k) % N_REQ]) exp_id = (model_ptr + k) % N_REQ;
          chk(id == exp_id, "rr_grant", id, exp_id);
          model_ptr = (id + 1) % N_REQ;
          a = sx(req_angle[id*AW +: AW]);
          exp_q.push_back('{id, q_cos(a), q_sin(a)});
          acc_cyc_q.push_back(cyc);
          grant_log.push_back(id);
          accepts++;
          load_chk = 1'b1;
          load_a   = a;
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (hs[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && cmd_q[i].size() > 0) begin
          req_angle[i*AW +: AW] = AW'(cmd_q[i].pop_front());
          req_valid[i] = 1'b1;
        end
      end
    end
  end

  // Behavioural CORDIC core: latches the angle on a load rising edge and
  // returns exact cos/sin after a fixed latency as a one-cycle pulse.
  initial begin
    bit prev;
    bit busy;
    int lat;
    int ang;
    core_x = '0;
    core_y = '0;
    core_data_computed = 1'b0;
    prev = 1'b0;
    busy = 1'b0;
    lat  = 0;
    ang  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        busy = 1'b0;
        prev = 1'b0;
        core_data_computed = 1'b0;
      end else begin
        if (core_data_computed) begin
          core_data_computed = 1'b0;
          chk(rsp_valid == 1'b1, "rsp_after_done", rsp_valid, 1);
        end
        if (core_data_loaded && !prev) begin
          load_pulses++;
          busy = 1'b1;
          lat  = CORE_LAT;
          ang  = sx(core_angle);
        end else if (busy) begin
          lat--;
          if (lat == 0) begin
            busy = 1'b0;
            if (!suppress) begin
              core_x = AW'(q_cos(ang));
              core_y = AW'(q_sin(ang));
              core_data_computed = 1'b1;
            end
          end
        end
        prev = core_data_loaded;
      end
    end
  end

  // Response-ready driver.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor: response stability while stalled, then pop and compare.
  initial begin
    bit   held_v;
    logic [ID_W-1:0] h_id;
    logic [AW-1:0]   h_cos;
    logic [AW-1:0]   h_sin;
    exp_t e;
    held_v = 1'b0;
    h_id = '0;
    h_cos = '0;
    h_sin = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else if (rsp_valid) begin
        if (held_v)
          chk(rsp_id == h_id && rsp_cos == h_cos && rsp_sin == h_sin, "rsp_stable",
              sx(rsp_cos), sx(h_cos));
        if (rsp_ready) begin
          held_v = 1'b0;
          rsp_cyc_q.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk(1'b0, "rsp_unexpected", rsp_id, -1);
          end else begin
            e = exp_q.pop_front();
            chk(int'(rsp_id) == e.id, "rsp_id", rsp_id, e.id);
            chk(iabs(sx(rsp_cos) - e.cosv) <= TOL, "rsp_cos", sx(rsp_cos), e.cosv);
            chk(iabs(sx(rsp_sin) - e.sinv) <= TOL, "rsp_sin", sx(rsp_sin), e.sinv);
          end
        end else begin
          held_v = 1'b1;
          h_id   = rsp_id;
          h_cos  = rsp_cos;
          h_sin  = rsp_sin;
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  task automatic check_zero(input string tag);
    chk(req_ready == '0, {tag, "_req_ready"}, req_ready, 0);
    chk(rsp_valid == 1'b0, {tag, "_rsp_valid"}, rsp_valid, 0);
    chk(rsp_id == '0, {tag, "_rsp_id"}, rsp_id, 0);
    chk(rsp_cos == '0, {tag, "_rsp_cos"}, rsp_cos, 0);
    chk(rsp_sin == '0, {tag, "_rsp_sin"}, rsp_sin, 0);
    chk(core_data_loaded == 1'b0, {tag, "_loaded"}, core_data_loaded, 0);
    chk(core_angle == '0, {tag, "_core_angle"}, core_angle, 0);
    chk(err_timeout == 1'b0, {tag, "_err"}, err_timeout, 0);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    bit busy;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      busy = (req_valid != '0) || (exp_q.size() != 0) || rsp_valid;
      for (int i = 0; i < N_REQ; i++) if (cmd_q[i].size() != 0) busy = 1'b1;
    end while (busy && n < budget);
    if (busy) chk(1'b0, "idle_timeout", n, budget);
  endtask

  task automatic wait_loaded(input string tag);
    int n;
    n = 0;
    while (!core_data_loaded && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!core_data_loaded) chk(1'b0, tag, 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Main sequence.
  initial begin
    int lp0;
    int base;
    int rbase;
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset");
    rst = 1'b0;

    // Single job at angle 0: one load pulse, cos = 1.0, sin = 0.
    lp0 = load_pulses;
    cmd_q[0].push_back(0);
    wait_idle(300);
    chk(load_pulses - lp0 == 1, "one_load_pulse", load_pulses - lp0, 1);

    // Directed angles including both fold paths and the fold boundaries.
    cmd_q[2].push_back(32'h0C90FE);
    cmd_q[1].push_back(PI_I);
    cmd_q[3].push_back(-32'h200000);
    cmd_q[0].push_back(-PI_I);
    cmd_q[2].push_back(HALF_I);
    cmd_q[1].push_back(-HALF_I);
    cmd_q[3].push_back(HALF_I + 1);
    wait_idle(1000);

    // All requesters valid back-to-back from a fresh pointer.
    do_reset();
    base  = acc_cyc_q.size();
    rbase = rsp_cyc_q.size();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N_REQ; i++) cmd_q[i].push_back(rand_angle());
    wait_idle(1000);
    for (int k = 0; k < 2 * N_REQ; k++)
      chk(grant_log[base + k] == k % N_REQ, "grant_order", grant_log[base + k], k % N_REQ);
    for (int k = 0; k < 2 * N_REQ - 1; k++)
      chk(acc_cyc_q[base + k + 1] - rsp_cyc_q[rbase + k] == 1, "one_bubble",
          acc_cyc_q[base + k + 1] - rsp_cyc_q[rbase + k], 1);

    // Response back-pressure: held data, no new accept while stalled.
    rdy_mode = 2;
    cmd_q[1].push_back(rand_angle());
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(rsp_valid == 1'b1, "stall_rsp_seen", rsp_valid, 1);
    cmd_q[3].push_back(rand_angle());
    repeat (10) begin
      @(negedge clk);
      chk(req_ready == '0, "no_accept_in_resp", req_ready, 0);
    end
    rdy_mode = 0;
    wait_idle(300);

    // Hung core: watchdog fires 64 cycles after the load pulse, no response.
    suppress = 1'b1;
    cmd_q[2].push_back(rand_angle());
    wait_loaded("timeout_load_seen");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err_timeout && n < 200);
    chk(n == TMO + 1, "timeout_cycles", n, TMO + 1);
    chk(rsp_valid == 1'b0, "timeout_no_rsp", rsp_valid, 0);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    suppress = 1'b0;
    cmd_q[0].push_back(rand_angle());
    wait_idle(300);
    chk(err_timeout == 1'b1, "err_sticky", err_timeout, 1);

    // Reset in the middle of a job abandons it.
    suppress = 1'b1;
    cmd_q[1].push_back(rand_angle());
    wait_loaded("rst_load_seen");
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_zero("midrst");
    exp_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    suppress = 1'b0;
    repeat (60) @(negedge clk);
    chk(rsp_valid == 1'b0, "midrst_no_rsp", rsp_valid, 0);

    // Randomised traffic with random response back-pressure.
    rdy_mode = 1;
    for (int k = 0; k < 30; k++) cmd_q[$urandom_range(0, N_REQ - 1)].push_back(rand_angle());
    wait_idle(6000);
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    chk(load_pulses == accepts, "load_per_accept", load_pulses, accepts);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
